// File: rtl/wavelet_readout.sv
// wavelet_readout: integrates signed sigma-delta feedback pulses on I/Q over
// windows of 2^WIN_LOG2 enabled cycles and shifts each window's sums out on a
// single serial pin with a frame-sync strobe. A window that closes while the
// previous frame is still shifting is dropped and raises sticky ovf.
// Optional feature macro: READOUT_PARITY_EN appends an even-parity bit.
module wavelet_readout #(
  parameter int WIN_LOG2 = 8
) (
  input  logic       clk_master,
  input  logic       rstb,
  input  logic       ud_en,
  input  logic [1:0] read_out_I,
  input  logic [1:0] read_out_Q,
  input  logic       sout_en,
  input  logic       clr_ovf,
  output logic       sdo,
  output logic       sfs,
  output logic       sbusy,
  output logic       ovf
);

  localparam int ACC_W = WIN_LOG2 + 2;
`ifdef READOUT_PARITY_EN
  localparam int FRAME_LEN = 2 * ACC_W + 1;
`else
  localparam int FRAME_LEN = 2 * ACC_W;
`endif
  localparam int BC_W = $clog2(FRAME_LEN);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // 01 -> +1, 10 -> -1, 00/11 -> 0
  function automatic logic signed [ACC_W-1:0] pulse_delta(input logic [1:0] p);
    case (p)
      2'b01:   return {{(ACC_W-1){1'b0}}, 1'b1};
      2'b10:   return {ACC_W{1'b1}};
      default: return {ACC_W{1'b0}};
    endcase
  endfunction

  logic [WIN_LOG2-1:0]     win_cnt_q;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i, sum_q;
  logic                    win_close;
  logic [FRAME_LEN-1:0]    frame_word;

  logic [0:0]           state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 last_bit;

  // Sums include the closing cycle's delta so the frame captures a full window
  assign sum_i     = acc_i_q + pulse_delta(read_out_I);
  assign sum_q     = acc_q_q + pulse_delta(read_out_Q);
  assign win_close = ud_en && (win_cnt_q == {WIN_LOG2{1'b1}});
  assign last_bit  = (bit_cnt_q == BC_W'(FRAME_LEN - 1));

`ifdef READOUT_PARITY_EN
  assign frame_word = {sum_i, sum_q, ^{sum_i, sum_q}};
`else
  assign frame_word = {sum_i, sum_q};
`endif

  // Window counter and accumulators advance only on qualified cycles
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      win_cnt_q <= '0;
      acc_i_q   <= '0;
      acc_q_q   <= '0;
    end else if (ud_en) begin
      win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
      if (win_close) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else begin
        acc_i_q <= sum_i;
        acc_q_q <= sum_q;
      end
    end
  end

  // Serializer next state: load on close when idle, drop and flag when busy
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ovf_d     = clr_ovf ? 1'b0 : ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (win_close) begin
          shift_d   = frame_word;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      default: begin
        if (win_close) begin
          ovf_d = 1'b1;
        end
        if (sout_en) begin
          shift_d   = {shift_q[FRAME_LEN-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
          if (last_bit) begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // Serializer state registers
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sbusy = (state_q == ST_SHIFT);
  assign sdo   = sbusy & shift_q[FRAME_LEN-1];
  assign sfs   = sbusy & (bit_cnt_q == '0);
  assign ovf   = ovf_q;

endmodule
